// File: rtl/mbssoc_mailbox_if.sv
// rtl/mbssoc_mailbox_if.sv - shared SoC bus between the bus controller and the mailbox responder
interface mbssoc_mailbox_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_re;
  logic              bus_we;
  logic              bus_sel;
  logic              bus_wait;

  modport master (
    output bus_addr, bus_wdata, bus_re, bus_we, bus_sel,
    input  bus_rdata, bus_wait
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_re, bus_we, bus_sel,
    output bus_rdata, bus_wait
  );
endinterface

// File: rtl/mbssoc_mailbox.sv
// rtl/mbssoc_mailbox.sv - inter-core mailbox: two word FIFOs (CPU0->CPU1, CPU1->CPU0) with level IRQs
module mbssoc_mailbox #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE       = 32'h0000_F000,
  parameter int                DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mbssoc_mailbox_if.slave      bus,
  output logic                 irq0,
  output logic                 irq1
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state, state_nx;
  logic [1:0]      lat_off, lat_off_nx;
  logic            lat_sel, lat_sel_nx;

  // FIFO index 0 is F01 (CPU0->CPU1), index 1 is F10; a core's outbound index equals its bus_sel
  logic [DATA_W-1:0]     mem [2][DEPTH];
  logic [DEPTH_LOG2-1:0] wp  [2];
  logic [DEPTH_LOG2-1:0] rp  [2];
  logic [DEPTH_LOG2:0]   cnt [2];
  logic [1:0]            empty, full;
  logic [1:0]            ovf, udf;
  logic [1:0]            ctrl;

  logic             hit, wr, push_req, pop_req, pop_f, in_f;
  logic [1:0]       off;
  logic [1:0]       do_push, do_pop;
  logic             ovf_set, udf_set;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rdata;
  logic              wait_req;

  assign hit      = (bus.bus_addr[ADDR_W-1:4] == BASE[ADDR_W-1:4]) && (bus.bus_addr[1:0] == 2'b00);
  assign off      = bus.bus_addr[3:2];
  assign wr       = hit & bus.bus_we;
  assign push_req = wr && (off == 2'd0);
  assign pop_req  = (state == RESP) && (lat_off == 2'd1);
  assign pop_f    = ~lat_sel;
  assign in_f     = ~lat_sel;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (cnt[i] == '0);
      full[i]  = cnt[i][DEPTH_LOG2];
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO may still land
  always_comb begin
    do_push = '0;
    do_pop  = '0;
    for (int i = 0; i < 2; i++) begin
      do_pop[i]  = pop_req && (pop_f == 1'(i)) && !empty[i];
      do_push[i] = push_req && (bus.bus_sel == 1'(i)) && (!full[i] || do_pop[i]);
    end
    ovf_set = push_req && full[bus.bus_sel] && !do_pop[bus.bus_sel];
    udf_set = pop_req && empty[pop_f];
  end

  always_comb begin
    rd_val = '0;
    case (lat_off)
      2'd1: if (!empty[in_f]) rd_val = mem[in_f][rp[in_f]];
      2'd2: begin
        rd_val[DEPTH_LOG2:0] = cnt[in_f];
        rd_val[8]            = empty[in_f];
        rd_val[9]            = full[lat_sel];
        rd_val[16]           = ovf[lat_sel];
        rd_val[17]           = udf[lat_sel];
      end
      2'd3: rd_val[1:0] = ctrl;
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    lat_off_nx = lat_off;
    lat_sel_nx = lat_sel;
    wait_req   = 1'b0;
    rdata      = '0;
    case (state)
      IDLE: begin
        if (bus.bus_re && hit && !bus.bus_we) begin
          wait_req   = 1'b1;
          lat_off_nx = off;
          lat_sel_nx = bus.bus_sel;
          state_nx   = RESP;
        end
      end
      RESP: begin
        rdata    = rd_val;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.bus_rdata = rdata;
  assign bus.bus_wait  = wait_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_off <= '0;
      lat_sel <= 1'b0;
      ovf     <= '0;
      udf     <= '0;
      ctrl    <= '0;
      irq0    <= 1'b0;
      irq1    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      lat_off <= lat_off_nx;
      lat_sel <= lat_sel_nx;
      for (int i = 0; i < 2; i++) begin
        if (do_push[i]) wp[i] <= wp[i] + 1'b1;
        if (do_pop[i])  rp[i] <= rp[i] + 1'b1;
        cnt[i] <= cnt[i] + {{DEPTH_LOG2{1'b0}}, do_push[i]} - {{DEPTH_LOG2{1'b0}}, do_pop[i]};
      end
      if (wr && off == 2'd3) begin
        ctrl <= bus.bus_wdata[1:0];
        if (bus.bus_wdata[16]) ovf[bus.bus_sel] <= 1'b0;
        if (bus.bus_wdata[17]) udf[bus.bus_sel] <= 1'b0;
      end
      if (ovf_set) ovf[bus.bus_sel] <= 1'b1;
      if (udf_set) udf[lat_sel] <= 1'b1;
      irq1 <= ctrl[1] & ~empty[0];
      irq0 <= ctrl[0] & ~empty[1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && do_push[i]) mem[i][wp[i]] <= bus.bus_wdata;
    end
  end
endmodule

// File: tb/tb_mbssoc_mailbox.sv
// tb/tb_mbssoc_mailbox.sv - scoreboard bench for mbssoc_mailbox with a queue-based reference model
module tb_mbssoc_mailbox;
  localparam logic [31:0] BASE = 32'h0000_F000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq0, irq1;

  mbssoc_mailbox_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mbssoc_mailbox #(.DATA_W(32), .ADDR_W(32), .BASE(BASE), .DEPTH_LOG2(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .irq0 (irq0),
    .irq1 (irq1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mq[0] is CPU0->CPU1, mq[1] is CPU1->CPU0
  logic [31:0] mq [2][$];
  logic [1:0]  movf = '0, mudf = '0, mctrl = '0;
  logic        mpend = 1'b0, mlsel = 1'b0;
  logic [1:0]  mloff = '0;

  logic [31:0] exp_q [$];
  logic        exp_irq0 = 1'b0, exp_irq1 = 1'b0, checking = 1'b0;
  logic        resp_due = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic s, input logic [1:0] o);
    logic [31:0] v;
    int in_i, out_i;
    v     = '0;
    in_i  = s ? 0 : 1;
    out_i = s ? 1 : 0;
    case (o)
      2'd1: if (mq[in_i].size() > 0) v = mq[in_i][0];
      2'd2: begin
        v[2:0] = 3'(mq[in_i].size());
        v[8]   = (mq[in_i].size() == 0);
        v[9]   = (mq[out_i].size() == 4);
        v[16]  = movf[s];
        v[17]  = mudf[s];
      end
      2'd3: v[1:0] = mctrl;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      chk("irq0", {31'b0, irq0}, {31'b0, exp_irq0});
      chk("irq1", {31'b0, irq1}, {31'b0, exp_irq1});
      if (resp_due) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          chk("rdata", bus.bus_rdata, exp_q.pop_front());
          last_rdata <= bus.bus_rdata;
        end
      end
    end
    resp_due <= bus.bus_wait;
  end

  // One bus cycle: drive inputs, advance the model, and wait past the clock edge
  task automatic step(input logic r, input logic re, input logic we, input logic s,
                      input logic [31:0] a, input logic [31:0] d);
    logic       hit, start;
    logic [1:0] o, stage;
    int         in_i, out_i;
    rst           = r;
    bus.bus_re    = re;
    bus.bus_we    = we;
    bus.bus_sel   = s;
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    hit   = ((a & 32'hFFFF_FFF3) == BASE);
    o     = a[3:2];
    start = !r && !mpend && re && hit && !we;
    #1;
    if (!r) chk("wait", {31'b0, bus.bus_wait}, {31'b0, start});
    stage = {mctrl[1] && (mq[0].size() != 0), mctrl[0] && (mq[1].size() != 0)};
    if (r) begin
      if (mpend) exp_q.push_back(model_read(mlsel, mloff));
      mq[0].delete();
      mq[1].delete();
      movf  = '0;
      mudf  = '0;
      mctrl = '0;
      mpend = 1'b0;
      stage = '0;
    end else begin
      if (mpend) begin
        exp_q.push_back(model_read(mlsel, mloff));
        if (mloff == 2'd1) begin
          in_i = mlsel ? 0 : 1;
          if (mq[in_i].size() > 0) void'(mq[in_i].pop_front());
          else mudf[mlsel] = 1'b1;
        end
        mpend = 1'b0;
      end else if (start) begin
        mpend = 1'b1;
        mlsel = s;
        mloff = o;
      end
      if (we && hit) begin
        if (o == 2'd0) begin
          out_i = s ? 1 : 0;
          if (mq[out_i].size() < 4) mq[out_i].push_back(d);
          else movf[s] = 1'b1;
        end else if (o == 2'd3) begin
          mctrl = d[1:0];
          if (d[16]) movf[s] = 1'b0;
          if (d[17]) mudf[s] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    {exp_irq1, exp_irq0} = stage;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic s, input logic [1:0] o, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b1, s, BASE + {28'b0, o, 2'b00}, d);
  endtask

  task automatic rd(input logic s, input logic [1:0] o, input logic cw, input logic cs,
                    input logic [31:0] cd, input logic hold);
    step(1'b0, 1'b1, 1'b0, s, BASE + {28'b0, o, 2'b00}, 32'h0);
    if (cw) step(1'b0, 1'b0, 1'b1, cs, BASE, cd);
    else    step(1'b0, hold, 1'b0, s, BASE + {28'b0, o, 2'b00}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic s;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    bus.bus_re    = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_sel   = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checking = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("rst_rdata", bus.bus_rdata, 32'h0);
    chk("rst_wait", {31'b0, bus.bus_wait}, 32'h0);
    rd(1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("status_after_reset", last_rdata, 32'h0000_0100);

    wr(1'b0, 2'd3, 32'h3);
    wr(1'b0, 2'd0, 32'hDEAD_BEEF);
    idle();
    idle();
    rd(1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rx_deadbeef", last_rdata, 32'hDEAD_BEEF);
    idle();
    idle();

    for (int i = 1; i <= 5; i++) wr(1'b0, 2'd0, 32'(i));
    rd(1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("cpu0_ovf_full", last_rdata & 32'h0003_0200, 32'h0001_0200);
    for (int i = 1; i <= 4; i++) begin
      rd(1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("pop_order", last_rdata, 32'(i));
    end
    rd(1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pop_empty", last_rdata, 32'h0);
    rd(1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("cpu1_udf", last_rdata[17], 1'b1);
    wr(1'b0, 2'd3, 32'h0001_0003);
    rd(1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ovf_cleared", last_rdata[16], 1'b0);

    for (int i = 0; i < 4; i++) wr(1'b0, 2'd0, 32'h10 + 32'(i));
    rd(1'b1, 2'd1, 1'b1, 1'b0, 32'hA, 1'b0);
    rd(1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("count_stays_4", last_rdata[2:0], 3'd4);
    for (int i = 0; i < 4; i++) rd(1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("a_read_last", last_rdata, 32'hA);

    step(1'b0, 1'b1, 1'b0, 1'b0, BASE + 32'h10, 32'h0);
    chk("miss_rdata", bus.bus_rdata, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, BASE, 32'h55);
    rd(1'b0, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("re_we_write", last_rdata, 32'h55);

    wr(1'b0, 2'd0, 32'h77);
    step(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_resp_rdata", bus.bus_rdata, 32'h0);
    chk("rst_resp_wait", {31'b0, bus.bus_wait}, 32'h0);
    rd(1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      s = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 11);
      case (k)
        0, 1, 2, 3: wr(s, 2'd0, $urandom);
        4, 5, 6:    rd(s, 2'd1, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), $urandom,
                       1'($urandom_range(0, 1)));
        7:          rd(s, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        8:          wr(s, 2'd3, $urandom);
        9:          step(1'b0, 1'b1, 1'b0, s, ($urandom_range(0, 1) == 0) ? BASE + 32'h10 : BASE + 32'h5, 32'h0);
        10:         step(1'b0, 1'b1, 1'b1, s, BASE, $urandom);
        default:    rd(s, 2'd3, 1'b0, 1'b0, 32'h0, 1'b0);
      endcase
    end

    idle();
    idle();
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
